// File: rtl/jtkunio_ram_arb.sv
// rtl/jtkunio_ram_arb.sv - scroll RAM arbiter between the 6502 bus and the video tile fetcher
module jtkunio_ram_arb #(
  parameter int AW      = 11,
  parameter int MAXWAIT = 3
) (
  input  logic          clk,
  input  logic          rst,
  // main CPU bus
  input  logic          cpu_cs,
  input  logic          cpu_rnw,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_dout,
  output logic [7:0]    cpu_din,
  output logic          cpu_ok,
  // scroll tile fetcher
  input  logic          vid_cs,
  input  logic [AW-1:0] vid_addr,
  output logic [7:0]    vid_data,
  output logic          vid_ok,
  // single-port synchronous RAM
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_din,
  output logic          ram_we,
  input  logic [7:0]    ram_dout
);

  // Starvation counter must hold 0..MAXWAIT; keep at least one bit so MAXWAIT=0 still elaborates.
  localparam int SW = (MAXWAIT < 1) ? 1 : $clog2(MAXWAIT + 1);
  localparam logic [SW-1:0] MAXW = SW'(MAXWAIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    LATCH  = 2'd2
  } state_t;

  state_t        st;
  logic [SW-1:0] starve;
  logic [AW-1:0] cpu_served;
  logic [AW-1:0] vid_served;
  logic          win_cpu;
  logic          win_rnw;
  logic          abort;

  logic          cpu_pend;
  logic          vid_pend;
  logic          grant_cpu;
  logic          grant_vid;
  logic          cpu_same;
  logic          vid_same;

  // A request is pending unless it is the one already acknowledged; a new
  // address under a held cs counts as a fresh request straight away.
  always_comb begin
    cpu_same  = (cpu_addr == cpu_served);
    vid_same  = (vid_addr == vid_served);
    cpu_pend  = cpu_cs & ~(cpu_ok & cpu_same);
    vid_pend  = vid_cs & ~(vid_ok & vid_same);
    grant_cpu = 1'b0;
    grant_vid = 1'b0;
    if (vid_pend && (!cpu_pend || starve < MAXW)) begin
      grant_vid = 1'b1;
    end else if (cpu_pend) begin
      grant_cpu = 1'b1;
    end
  end

  // Three-step access sequencer: grant in IDLE, RAM cycle in ACCESS, capture in LATCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= IDLE;
      starve     <= '0;
      cpu_served <= '0;
      vid_served <= '0;
      win_cpu    <= 1'b0;
      win_rnw    <= 1'b0;
      abort      <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      ram_we     <= 1'b0;
      cpu_din    <= '0;
      cpu_ok     <= 1'b0;
      vid_data   <= '0;
      vid_ok     <= 1'b0;
    end else begin
      // ok only acknowledges the served request; drop it once cs or the address moves on
      if (cpu_ok && (!cpu_cs || !cpu_same)) cpu_ok <= 1'b0;
      if (vid_ok && (!vid_cs || !vid_same)) vid_ok <= 1'b0;

      case (st)
        IDLE: begin
          if (!cpu_cs) starve <= '0;
          if (grant_vid) begin
            win_cpu    <= 1'b0;
            win_rnw    <= 1'b1;
            ram_addr   <= vid_addr;
            ram_din    <= cpu_dout;
            vid_served <= vid_addr;
            abort      <= 1'b0;
            if (cpu_pend && starve != MAXW) starve <= starve + SW'(1);
            st         <= ACCESS;
          end else if (grant_cpu) begin
            win_cpu    <= 1'b1;
            win_rnw    <= cpu_rnw;
            ram_addr   <= cpu_addr;
            ram_din    <= cpu_dout;
            ram_we     <= ~cpu_rnw;
            cpu_served <= cpu_addr;
            abort      <= 1'b0;
            starve     <= '0;
            st         <= ACCESS;
          end
        end
        ACCESS: begin
          ram_we <= 1'b0;
          if (win_cpu ? !cpu_cs : !vid_cs) abort <= 1'b1;
          st     <= LATCH;
        end
        LATCH: begin
          if (win_cpu) begin
            if (win_rnw) cpu_din <= ram_dout;
            if (!abort && cpu_cs && cpu_same) cpu_ok <= 1'b1;
          end else begin
            vid_data <= ram_dout;
            if (!abort && vid_cs && vid_same) vid_ok <= 1'b1;
          end
          st <= IDLE;
        end
        default: begin
          ram_we <= 1'b0;
          st     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtkunio_ram_arb.sv
// tb/tb_jtkunio_ram_arb.sv - directed bench with transaction-level memory model for jtkunio_ram_arb
module tb_jtkunio_ram_arb;

  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_cs;
  logic          cpu_rnw;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_dout;
  logic [7:0]    cpu_din;
  logic          cpu_ok;
  logic          vid_cs;
  logic [AW-1:0] vid_addr;
  logic [7:0]    vid_data;
  logic          vid_ok;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_din;
  logic          ram_we;
  logic [7:0]    ram_dout;

  logic [7:0]    mem [0:2047];
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [7:0]    pl_data;

  int n_cmp = 0;
  int n_bad = 0;

  jtkunio_ram_arb #(.AW(AW), .MAXWAIT(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_cs   (cpu_cs),
    .cpu_rnw  (cpu_rnw),
    .cpu_addr (cpu_addr),
    .cpu_dout (cpu_dout),
    .cpu_din  (cpu_din),
    .cpu_ok   (cpu_ok),
    .vid_cs   (vid_cs),
    .vid_addr (vid_addr),
    .vid_data (vid_data),
    .vid_ok   (vid_ok),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_dout (ram_dout)
  );

  always #5 clk = ~clk;

  // synchronous single-port RAM with a bench-side preload port
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    if (pl_en)  mem[pl_addr]  <= pl_data;
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Memory-level model: a read acknowledged by ok must return the last value
  // stored at that address; a write acknowledged by ok updates the model.
  task automatic model_loop();
    logic [7:0] ref_mem [0:2047];
    logic [7:0] m_cpu_exp;
    logic [7:0] m_vid_exp;
    logic       m_cpu_rd;
    logic       p_cpu;
    logic       p_vid;
    for (int i = 0; i < 2048; i++) ref_mem[i] = 8'h00;
    m_cpu_exp = 8'h00; m_vid_exp = 8'h00; m_cpu_rd = 1'b0; p_cpu = 1'b0; p_vid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (pl_en) ref_mem[pl_addr] = pl_data;
      if (rst) begin
        chk("model_rst_cpu_ok", cpu_ok, 0);
        chk("model_rst_vid_ok", vid_ok, 0);
        chk("model_rst_ram_we", ram_we, 0);
        m_cpu_exp = 8'h00; m_vid_exp = 8'h00; m_cpu_rd = 1'b0; p_cpu = 1'b0; p_vid = 1'b0;
      end else begin
        if (cpu_ok && !p_cpu) begin
          m_cpu_rd = cpu_rnw;
          if (cpu_rnw) m_cpu_exp = ref_mem[cpu_addr];
          else         ref_mem[cpu_addr] = cpu_dout;
        end
        if (vid_ok && !p_vid) m_vid_exp = ref_mem[vid_addr];
        if (cpu_ok && m_cpu_rd) chk("model_cpu_din", cpu_din, m_cpu_exp);
        if (vid_ok) chk("model_vid_data", vid_data, m_vid_exp);
        if (ram_we) chk("model_we_only_cpu_write", cpu_cs & ~cpu_rnw, 1);
        p_cpu = cpu_ok;
        p_vid = vid_ok;
      end
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    step();
    pl_en = 1'b0;
  endtask

  task automatic cpu_access(input logic rnw, input logic [AW-1:0] a, input logic [7:0] d,
                            output int lat, output int wes);
    cpu_rnw = rnw; cpu_addr = a; cpu_dout = d; cpu_cs = 1'b1;
    lat = 0; wes = 0;
    while (!cpu_ok && lat < 20) begin
      step();
      lat++;
      if (ram_we) wes++;
    end
    cpu_cs = 1'b0;
    step();
  endtask

  // video and CPU request in the same cycle; each side drops cs when served
  task automatic tie(input logic [AW-1:0] va, input logic [AW-1:0] ca,
                     output int vn, output int cn, output int vd, output int cd);
    vid_addr = va; vid_cs = 1'b1;
    cpu_rnw = 1'b1; cpu_addr = ca; cpu_cs = 1'b1;
    vn = 0; cn = 0; vd = 0; cd = 0;
    for (int n = 1; n <= 20 && (vn == 0 || cn == 0); n++) begin
      step();
      if (vid_ok && vn == 0) begin vn = n; vd = vid_data; vid_cs = 1'b0; end
      if (cpu_ok && cn == 0) begin cn = n; cd = cpu_din; cpu_cs = 1'b0; end
    end
    vid_cs = 1'b0; cpu_cs = 1'b0;
    step();
  endtask

  initial begin
    int lat, wes, vn, cn, vd, cd, vg, v1, v3, seen, m;
    logic pv;
    rst = 1'b1;
    cpu_cs = 1'b0; cpu_rnw = 1'b1; cpu_addr = '0; cpu_dout = 8'h00;
    vid_cs = 1'b0; vid_addr = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = 8'h00;
    fork
      model_loop();
    join_none
    step();
    step();
    chk("rst_cpu_din", cpu_din, 0);
    chk("rst_cpu_ok", cpu_ok, 0);
    chk("rst_vid_data", vid_data, 0);
    chk("rst_vid_ok", vid_ok, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_din", ram_din, 0);
    chk("rst_ram_we", ram_we, 0);
    rst = 1'b0;

    // reset in the middle of a CPU write
    preload(11'h123, 8'h5A);
    cpu_rnw = 1'b0; cpu_addr = 11'h123; cpu_dout = 8'hEE; cpu_cs = 1'b1;
    step();
    chk("abort_we_in_access", ram_we, 1);
    #1;
    rst = 1'b1; cpu_cs = 1'b0;
    #1;
    chk("abort_we_async", ram_we, 0);
    chk("abort_ram_addr", ram_addr, 0);
    chk("abort_ram_din", ram_din, 0);
    chk("abort_cpu_ok", cpu_ok, 0);
    step();
    rst = 1'b0;
    cpu_access(1'b1, 11'h123, 8'h00, lat, wes);
    chk("abort_mem_kept", cpu_din, 8'h5A);

    // single write then read back
    cpu_access(1'b0, 11'h055, 8'hA5, lat, wes);
    chk("wr_latency", lat, 3);
    chk("wr_we_cycles", wes, 1);
    cpu_access(1'b1, 11'h055, 8'h00, lat, wes);
    chk("rd_latency", lat, 3);
    chk("rd_we_cycles", wes, 0);
    chk("rd_data", cpu_din, 8'hA5);

    // simultaneous requests: video first, CPU next
    preload(11'h010, 8'h3C);
    preload(11'h020, 8'h77);
    tie(11'h010, 11'h020, vn, cn, vd, cd);
    chk("tie_vid_latency", vn, 3);
    chk("tie_cpu_latency", cn, 6);
    chk("tie_vid_data", vd, 8'h3C);
    chk("tie_cpu_data", cd, 8'h77);

    // starvation: video re-armed on every ok while the CPU waits
    for (int i = 0; i < 4; i++) preload(11'h100 + 11'(i), 8'hB0 + 8'(i));
    preload(11'h030, 8'h99);
    vid_addr = 11'h100; vid_cs = 1'b1;
    cpu_rnw = 1'b1; cpu_addr = 11'h030; cpu_cs = 1'b1;
    vg = 0; cn = 0; v1 = 0; v3 = 0; cd = 0; pv = 1'b0;
    for (int n = 1; n <= 40 && cn == 0; n++) begin
      step();
      if (cpu_ok) begin
        cn = n; cd = cpu_din; cpu_cs = 1'b0;
      end else if (vid_ok && !pv) begin
        vg++;
        if (vg == 1) v1 = n;
        if (vg == 3) v3 = n;
        vid_addr = 11'h100 + 11'(vg);
      end
      pv = vid_ok;
    end
    chk("starve_vid_grants", vg, 3);
    chk("starve_first_vid", v1, 3);
    chk("starve_third_vid", v3, 9);
    chk("starve_cpu_latency", cn, 12);
    chk("starve_cpu_data", cd, 8'h99);
    m = 0;
    for (int n = 1; n <= 10 && m == 0; n++) begin
      step();
      if (vid_ok) m = n;
    end
    chk("starve_vid_after_cpu", m, 3);
    chk("starve_vid_after_data", vid_data, 8'hB3);
    vid_cs = 1'b0;
    step();
    tie(11'h010, 11'h020, vn, cn, vd, cd);
    chk("starve_cleared_vid_first", vn, 3);
    chk("starve_cleared_cpu_next", cn, 6);

    // CPU drops cs during ACCESS
    preload(11'h040, 8'h42);
    cpu_rnw = 1'b1; cpu_addr = 11'h040; cpu_cs = 1'b1;
    step();
    cpu_cs = 1'b0;
    seen = 0;
    for (int n = 0; n < 6; n++) begin
      step();
      if (cpu_ok) seen = 1;
    end
    chk("drop_no_ok", seen, 0);
    chk("drop_data_latched", cpu_din, 8'h42);
    cpu_access(1'b1, 11'h055, 8'h00, lat, wes);
    chk("drop_next_latency", lat, 3);
    chk("drop_next_data", cpu_din, 8'hA5);

    // address change while cs stays high
    preload(11'h001, 8'h11);
    preload(11'h002, 8'h22);
    cpu_rnw = 1'b1; cpu_addr = 11'h001; cpu_cs = 1'b1;
    lat = 0;
    while (!cpu_ok && lat < 20) begin step(); lat++; end
    chk("achg_first_latency", lat, 3);
    chk("achg_first_data", cpu_din, 8'h11);
    cpu_addr = 11'h002;
    step();
    chk("achg_ok_falls", cpu_ok, 0);
    lat = 1;
    while (!cpu_ok && lat < 20) begin step(); lat++; end
    chk("achg_second_latency", lat, 3);
    chk("achg_second_data", cpu_din, 8'h22);
    step();
    chk("achg_ok_held", cpu_ok, 1);
    cpu_cs = 1'b0;
    step();
    chk("achg_ok_falls_on_cs", cpu_ok, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
